// File: rtl/router_input_buffer.sv
// router_input_buffer: per-port NoC input FIFO with credit flow control and packet framing FSM
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   rx, data_i          : incoming link flit; credit_o high while a slot is free
//   h, ack_h            : header request / grant towards switch control
//   data_av, data_o, data_ack : head-flit handshake towards the crossbar
//   sender              : packet transfer in progress
//   occupancy           : flits stored; overflow: sticky flag for a flit dropped while full
//   ROUTER_INPUT_BUFFER_STATS_EN adds pkt_count and flit_count (32-bit, wrapping)
module router_input_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int SIZE_WIDTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic credit_o,
  output logic h,
  input  logic ack_h,
  output logic data_av,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic data_ack,
  output logic sender,
  output logic [$clog2(DEPTH):0] occupancy,
`ifdef ROUTER_INPUT_BUFFER_STATS_EN
  output logic overflow,
  output logic [31:0] pkt_count,
  output logic [31:0] flit_count
`else
  output logic overflow
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HEAD, S_SIZE, S_PAYLOAD, S_END} state_t;
  state_t r_state;
  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic [SIZE_WIDTH-1:0] r_rem;
  logic r_h, r_sender, r_ovf;
  logic w_push, w_pop;
  logic [SIZE_WIDTH-1:0] w_size;
  assign credit_o = r_cnt != (AW+1)'(DEPTH);
  assign w_push = rx && credit_o;
  // sender is high exactly in HEAD/SIZE/PAYLOAD, so it gates flit delivery
  assign data_av = r_sender && r_cnt != '0;
  assign w_pop = data_av && data_ack;
  assign data_o = r_mem[r_rd];
  assign w_size = data_o[SIZE_WIDTH-1:0];
  assign occupancy = r_cnt;
  assign h = r_h;
  assign sender = r_sender;
  assign overflow = r_ovf;
  // memory is cleared on reset so data_o reads 0 afterwards
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= data_i;
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (rx && !credit_o) r_ovf <= 1'b1;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_h <= 1'b0;
      r_sender <= 1'b0;
      r_rem <= '0;
    end else
      case (r_state)
        S_IDLE: if (r_cnt != '0) begin
          r_state <= S_REQ;
          r_h <= 1'b1;
        end
        S_REQ: if (ack_h) begin
          r_state <= S_HEAD;
          r_h <= 1'b0;
          r_sender <= 1'b1;
        end
        S_HEAD: if (w_pop) r_state <= S_SIZE;
        S_SIZE: if (w_pop) begin
          r_rem <= w_size;
          r_sender <= w_size != '0;
          if (w_size == '0) r_state <= S_END;
          else r_state <= S_PAYLOAD;
        end
        S_PAYLOAD: if (w_pop) begin
          r_rem <= r_rem - SIZE_WIDTH'(1);
          if (r_rem == SIZE_WIDTH'(1)) begin
            r_state <= S_END;
            r_sender <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef ROUTER_INPUT_BUFFER_STATS_EN
  logic [31:0] r_pkt, r_flit;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_pkt <= '0;
      r_flit <= '0;
    end else begin
      if (w_pop && r_state == S_SIZE) r_pkt <= r_pkt + 32'd1;
      if (w_pop) r_flit <= r_flit + 32'd1;
    end
  assign pkt_count = r_pkt;
  assign flit_count = r_flit;
`endif
endmodule

// File: doc/router_input_buffer.md
Name: router_input_buffer

Overview:
- Parametrised per-port input buffer for the credit-based NoC router.
- Replaces the fixed 32-bit, 5-port flit assumptions with configurable flit width, buffer depth and size-field width.
- Accepts flits on the rx/data_i/credit_o link side and stores them in a circular FIFO.
- Tracks packet framing (header, size, payload) and drives a header request/grant and flit handshake towards the router's switch control and crossbar.

Parameters:
FLIT_WIDTH, 32, flit width in bits
DEPTH, 16, FIFO depth in flits; power of two, >= 2
SIZE_WIDTH, 16, low bits of the size flit used as payload count; <= FLIT_WIDTH

Ports:
clock  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  link valid; flit on data_i this cycle
data_i  input  FLIT_WIDTH  incoming flit
credit_o  output  1  buffer can accept a flit this cycle
h  output  1  header request to switch control
ack_h  input  1  header grant from switch control
data_av  output  1  flit valid towards crossbar
data_o  output  FLIT_WIDTH  FIFO head flit
data_ack  input  1  crossbar consumed data_o
sender  output  1  packet transfer in progress (connection held)
occupancy  output  $clog2(DEPTH)+1  flits currently stored
overflow  output  1  sticky: rx seen while credit_o=0

Behaviour:
- Reset (async, reset=1): all of the following are cleared.
  - Pointers and count cleared; occupancy=0; credit_o=1; h=0; data_av=0; sender=0; overflow=0.
  - data_o=0; FSM=IDLE.
  - Reset mid-packet discards all stored flits and framing state.
- credit_o = (occupancy != DEPTH), driven combinationally from registered count.
- Push occurs when rx && credit_o. Flit is written at wr_ptr; wr_ptr wraps modulo DEPTH.
- rx && !credit_o: flit dropped, overflow set, and overflow stays set until reset.
- Pop occurs when data_av && data_ack. rd_ptr wraps modulo DEPTH.
- Simultaneous push and pop: occupancy unchanged.
  - When full, credit_o=0, so a same-cycle pop does not enable a push.
- No bypass: a flit written in cycle N is visible on data_o and eligible for h/data_av from cycle N+1.
- data_o always shows mem[rd_ptr]. Its value is don't-care when empty, except after reset (0).
- FSM, registered state:
  - IDLE: h=0, sender=0. If occupancy>0 -> REQ.
  - REQ: h=1 until ack_h=1. On ack_h -> HEAD, with sender=1 from the next cycle.
  - HEAD: data_av = (occupancy>0). On pop -> SIZE.
  - SIZE: data_av = (occupancy>0). On pop, remaining <= data_o[SIZE_WIDTH-1:0].
    - If that value is 0 -> END.
    - Otherwise -> PAYLOAD.
  - PAYLOAD: data_av = (occupancy>0). Each pop decrements remaining. Pop with remaining==1 -> END.
  - END: one cycle, sender=0, data_av=0 -> IDLE.
- Minimum packet is 2 flits; a size of 0 means header and size only.
- sender=1 throughout HEAD, SIZE and PAYLOAD.
- Flit consumption is gated by data_av; an empty FIFO mid-packet stalls without error.
- h is deasserted the cycle after ack_h is sampled. ack_h in any state other than REQ is ignored.
- remaining is SIZE_WIDTH bits wide. Size flit bits above SIZE_WIDTH are ignored.

Optional Feature:
- Macro ROUTER_INPUT_BUFFER_STATS_EN.
- Defined: adds outputs pkt_count (32 bits) and flit_count (32 bits), both reset to 0.
  - pkt_count increments on every SIZE->PAYLOAD/END transition, i.e. once per packet.
  - flit_count increments on every pop.
  - Both wrap from 2^32-1 to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single packet: push 0x00000011, 0x00000003, 0xA, 0xB, 0xC with ack_h one cycle after h and data_ack=1.
  - h rises the cycle after the first push.
  - data_o shows the 5 flits in order.
  - sender falls after 0xC is popped; FSM returns to IDLE.
- Fill to full: DEPTH=16, push 16 flits with data_ack=0.
  - credit_o=0 and occupancy=16.
  - A 17th rx sets overflow=1 and is dropped.
  - After one pop, credit_o=1.
- Zero-size packet: header 0x22, size 0x0.
  - Exactly 2 pops, then END for one cycle, then IDLE.
  - A following packet triggers a fresh h.
- Wrap and concurrency: 40 back-to-back flits (multiple packets) with data_ack=1 every cycle.
  - Order preserved across pointer wrap.
  - occupancy never exceeds DEPTH.
- Stall mid-payload: size 4, rx gap of 3 cycles after the 2nd payload flit.
  - data_av=0 during the gap and sender stays 1.
  - Transfer resumes and completes correctly.
- Reset mid-packet: assert reset during PAYLOAD with occupancy=5.
  - Outputs immediately (async) take their reset values.
  - The next packet is framed from a fresh header.
  - With STATS_EN: pkt_count=1 after the single-packet test, and 0 after reset.
